// File: rtl/udm_accel_bridge_pkg.sv
// Shared register map, STATUS layout and helpers for the UDM accelerator bridge.
package udm_accel_bridge_pkg;

  // Offsets inside the 4 KB accelerator CSR window
  localparam logic [11:0] CTRL_OFF      = 12'h000;
  localparam logic [11:0] STATUS_OFF    = 12'h004;
  localparam logic [11:0] RESP_DATA_OFF = 12'h008;
  localparam logic [11:0] CMD_BASE_OFF  = 12'h040;

  // Offsets from the GPIO base
  localparam logic [31:0] LED_OFF = 32'h0000_0000;
  localparam logic [31:0] SW_OFF  = 32'h0000_0004;

  // STATUS register layout
  localparam int unsigned ST_BUSY_BIT      = 0;
  localparam int unsigned ST_UNDERFLOW_BIT = 1;
  localparam int unsigned ST_FULL_BIT      = 2;
  localparam int unsigned ST_COUNT_LSB     = 8;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Replace only the bytes whose enable is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/udm_resp_fifo.sv
// Synchronous FIFO holding accelerator responses until the UDM master reads them.
module udm_resp_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH_POW = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_POW:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_POW;
  // Keep at least one pointer bit so a depth-1 FIFO still elaborates
  localparam int unsigned PTR_W = (DEPTH_POW == 0) ? 1 : DEPTH_POW;
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [DEPTH_POW:0] FULL_CNT = (DEPTH_POW + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_POW:0] count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap explicitly at DEPTH-1
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DEPTH_POW + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_POW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/udm_accel_bridge.sv
// UDM bus slave: command staging/launch to one accelerator, response FIFO, LED/SW GPIO.
module udm_accel_bridge
  import udm_accel_bridge_pkg::*;
#(
  parameter int unsigned CMD_WORDS           = 4,
  parameter int unsigned RESP_FIFO_DEPTH_POW = 3,
  parameter logic [31:0] CSR_BASE            = 32'h1000_0000,
  parameter logic [31:0] GPIO_BASE           = 32'h0000_0000,
  parameter int unsigned LED_WIDTH           = 16,
  parameter int unsigned SW_WIDTH            = 16,
  parameter logic [31:0] ERR_DATA            = ERR_DATA_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      bus_req_i,
  input  logic                      bus_we_i,
  input  logic [31:0]               bus_addr_bi,
  input  logic [3:0]                bus_be_bi,
  input  logic [31:0]               bus_wdata_bi,
  output logic                      bus_ack_o,
  output logic                      bus_resp_o,
  output logic [31:0]               bus_rdata_bo,
  input  logic [SW_WIDTH-1:0]       sw_i,
  output logic [LED_WIDTH-1:0]      led_o,
  output logic                      cmd_req_o,
  output logic [CMD_WORDS*32-1:0]   cmd_data_bo,
  input  logic                      cmd_ack_i,
  input  logic                      resp_req_i,
  input  logic [31:0]               resp_data_bi,
  output logic                      resp_ack_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam int unsigned CNT_W = RESP_FIFO_DEPTH_POW + 1;

  logic [0:0]              state_q, state_d;
  logic [CMD_WORDS*32-1:0] cmd_data_q, cmd_data_d;
  logic [31:0]             stage_q [CMD_WORDS];
  logic [31:0]             stage_d [CMD_WORDS];
  logic [LED_WIDTH-1:0]    led_q, led_d;
  logic                    underflow_q, underflow_d;
  logic                    resp_q, resp_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    csr_hit, led_hit, sw_hit;
  logic [11:0]             csr_off;
  logic                    cmd_busy, launch_req, bus_acc, wr_acc, rd_acc, launch;
  logic                    resp_rd, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [31:0]             fifo_head, status_w;

  assign csr_hit = (bus_addr_bi[31:12] == CSR_BASE[31:12]);
  assign csr_off = bus_addr_bi[11:0];
  assign led_hit = (bus_addr_bi == GPIO_BASE + LED_OFF);
  assign sw_hit  = (bus_addr_bi == GPIO_BASE + SW_OFF);

  assign cmd_busy   = (state_q == ST_BUSY);
  assign launch_req = bus_req_i && bus_we_i && csr_hit && (csr_off == CTRL_OFF) && bus_wdata_bi[0];
  // A launch against an occupied slot stalls, but may complete on the handshake cycle itself
  assign bus_ack_o  = bus_req_i && !(launch_req && cmd_busy && !cmd_ack_i);
  assign bus_acc    = bus_req_i && bus_ack_o;
  assign wr_acc     = bus_acc && bus_we_i;
  assign rd_acc     = bus_acc && !bus_we_i;
  assign launch     = bus_acc && launch_req;

  assign resp_rd    = rd_acc && csr_hit && (csr_off == RESP_DATA_OFF);
  assign fifo_pop   = resp_rd && !fifo_empty;
  assign resp_ack_o = !fifo_full;
  assign fifo_push  = resp_req_i && resp_ack_o;

  udm_resp_fifo #(
    .WIDTH     (32),
    .DEPTH_POW (RESP_FIFO_DEPTH_POW)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (resp_data_bi),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // STATUS view: unused bits read as zero
  always_comb begin
    status_w                      = '0;
    status_w[ST_BUSY_BIT]         = cmd_busy;
    status_w[ST_UNDERFLOW_BIT]    = underflow_q;
    status_w[ST_FULL_BIT]         = fifo_full;
    status_w[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
  end

  // Byte-enabled register writes, W1C underflow and underflow detection
  always_comb begin
    stage_d     = stage_q;
    led_d       = led_q;
    underflow_d = underflow_q;
    if (wr_acc) begin
      for (int unsigned i = 0; i < CMD_WORDS; i++) begin
        if (csr_hit && (csr_off == CMD_BASE_OFF + 12'(4 * i)))
          stage_d[i] = be_merge(stage_q[i], bus_wdata_bi, bus_be_bi);
      end
      if (csr_hit && (csr_off == STATUS_OFF) && bus_be_bi[0] && bus_wdata_bi[ST_UNDERFLOW_BIT])
        underflow_d = 1'b0;
      if (!csr_hit && led_hit)
        led_d = LED_WIDTH'(be_merge(32'(led_q), bus_wdata_bi, bus_be_bi));
    end
    if (resp_rd && fifo_empty) underflow_d = 1'b1;
  end

  // Launch FSM: a launch snapshots staging; the handshake frees the slot unless relaunched
  always_comb begin
    state_d    = state_q;
    cmd_data_d = cmd_data_q;
    if (launch) begin
      state_d = ST_BUSY;
      for (int unsigned i = 0; i < CMD_WORDS; i++) cmd_data_d[32*i +: 32] = stage_q[i];
    end else if (cmd_busy && cmd_ack_i) begin
      state_d = ST_IDLE;
    end
  end

  // Read mux; CTRL is write-only and reads as zero, anything unmapped returns ERR_DATA
  always_comb begin
    rdata_d = rdata_q;
    resp_d  = rd_acc;
    if (rd_acc) begin
      rdata_d = ERR_DATA;
      if (csr_hit) begin
        if (csr_off == CTRL_OFF)           rdata_d = '0;
        else if (csr_off == STATUS_OFF)    rdata_d = status_w;
        else if (csr_off == RESP_DATA_OFF) rdata_d = fifo_empty ? '0 : fifo_head;
        else begin
          for (int unsigned i = 0; i < CMD_WORDS; i++) begin
            if (csr_off == CMD_BASE_OFF + 12'(4 * i)) rdata_d = stage_q[i];
          end
        end
      end else if (led_hit) begin
        rdata_d = 32'(led_q);
      end else if (sw_hit) begin
        rdata_d = 32'(sw_i);
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_data_q  <= '0;
      for (int unsigned i = 0; i < CMD_WORDS; i++) stage_q[i] <= '0;
      led_q       <= '0;
      underflow_q <= 1'b0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_data_q  <= cmd_data_d;
      stage_q     <= stage_d;
      led_q       <= led_d;
      underflow_q <= underflow_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign led_o        = led_q;
  assign cmd_req_o    = cmd_busy;
  assign cmd_data_bo  = cmd_data_q;
  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;

endmodule

// File: tb/tb_udm_accel_bridge.sv
// Scoreboard bench for udm_accel_bridge with a queue-based reference model.
module tb_udm_accel_bridge;

  localparam int CW    = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] CSR  = 32'h1000_0000;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_req = 1'b0, bus_we = 1'b0;
  logic [31:0]   bus_addr = '0, bus_wdata = '0;
  logic [3:0]    bus_be = '0;
  logic          bus_ack, bus_resp;
  logic [31:0]   bus_rdata;
  logic [15:0]   sw = '0;
  logic [15:0]   led;
  logic          cmd_req, cmd_ack = 1'b0;
  logic [127:0]  cmd_data;
  logic          resp_req = 1'b0, resp_ack;
  logic [31:0]   resp_data = '0;

  always #5 clk = ~clk;

  udm_accel_bridge #(
    .CMD_WORDS           (CW),
    .RESP_FIFO_DEPTH_POW (3),
    .CSR_BASE            (CSR),
    .GPIO_BASE           (32'h0),
    .LED_WIDTH           (16),
    .SW_WIDTH            (16),
    .ERR_DATA            (ERR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_req_i    (bus_req),
    .bus_we_i     (bus_we),
    .bus_addr_bi  (bus_addr),
    .bus_be_bi    (bus_be),
    .bus_wdata_bi (bus_wdata),
    .bus_ack_o    (bus_ack),
    .bus_resp_o   (bus_resp),
    .bus_rdata_bo (bus_rdata),
    .sw_i         (sw),
    .led_o        (led),
    .cmd_req_o    (cmd_req),
    .cmd_data_bo  (cmd_data),
    .cmd_ack_i    (cmd_ack),
    .resp_req_i   (resp_req),
    .resp_data_bi (resp_data),
    .resp_ack_o   (resp_ack)
  );

  int unsigned compared = 0, mismatched = 0;

  logic [31:0]  exp_rd_q [$];
  logic [127:0] exp_cmd_q [$];

  // reference model state
  logic [31:0] m_stage [CW];
  logic [31:0] m_fifo [$];
  logic        m_under = 1'b0, m_busy = 1'b0;
  logic [15:0] m_led = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [127:0] pack_stage();
    logic [127:0] p;
    for (int i = 0; i < CW; i++) p[32*i +: 32] = m_stage[i];
    return p;
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(m_fifo.size()), 5'h0, (m_fifo.size() == DEPTH), m_under, m_busy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CW; i++) m_stage[i] = '0;
    m_fifo.delete();
    exp_cmd_q.delete();
    m_under = 1'b0;
    m_busy  = 1'b0;
    m_led   = '0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    m = bmask(be);
    if (a == CSR) begin
      if (d[0]) begin
        exp_cmd_q.push_back(pack_stage());
        m_busy = 1'b1;
      end
    end else if (a == CSR + 32'h4) begin
      if (be[0] && d[1]) m_under = 1'b0;
    end else if (a == 32'h0) begin
      m_led = 16'((32'(m_led) & ~m) | (d & m));
    end else begin
      for (int i = 0; i < CW; i++)
        if (a == CSR + 32'h40 + 32'(4 * i)) m_stage[i] = (m_stage[i] & ~m) | (d & m);
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] e);
    e = ERR;
    if (a == CSR + 32'h4) e = m_status();
    else if (a == CSR + 32'h8) begin
      if (m_fifo.size() > 0) e = m_fifo.pop_front();
      else begin
        e = '0;
        m_under = 1'b1;
      end
    end else if (a == 32'h0) e = {16'h0, m_led};
    else if (a == 32'h4) e = {16'h0, sw};
    else begin
      for (int i = 0; i < CW; i++)
        if (a == CSR + 32'h40 + 32'(4 * i)) e = m_stage[i];
    end
  endtask

  // Monitor: bus read responses and the command port against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_resp) begin
        if (exp_rd_q.size() == 0) check("unexpected_resp", 128'(bus_resp), 128'(0));
        else check("rdata", 128'(bus_rdata), 128'(exp_rd_q.pop_front()));
      end
      if (cmd_req) begin
        if (exp_cmd_q.size() == 0) check("unexpected_cmd_req", 128'(cmd_req), 128'(0));
        else begin
          check("cmd_data", cmd_data, exp_cmd_q[0]);
          if (cmd_ack) void'(exp_cmd_q.pop_front());
        end
      end
    end
  end

  task automatic bus_xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output bit ok);
    @(posedge clk); #1;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d; bus_be = be;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ack_timeout", 128'(bus_ack), 128'(1));
    @(posedge clk); #1;
    bus_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bit ok;
    bus_xact(1'b1, a, d, be, ok);
    if (ok) model_write(a, d, be);
  endtask

  task automatic rd(input logic [31:0] a);
    bit ok;
    logic [31:0] e;
    model_read(a, e);
    exp_rd_q.push_back(e);
    bus_xact(1'b0, a, '0, 4'hF, ok);
    @(negedge clk);
    check("resp_latency", 128'(bus_resp), 128'(1));
  endtask

  task automatic push_resp(input logic [31:0] d);
    @(posedge clk); #1;
    resp_req = 1'b1; resp_data = d;
    @(negedge clk);
    check("resp_ack", 128'(resp_ack), 128'(m_fifo.size() < DEPTH));
    if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
    @(posedge clk); #1;
    resp_req = 1'b0;
  endtask

  // RESP_DATA read and accelerator push in the same cycle
  task automatic push_pop(input logic [31:0] d);
    logic [31:0] e;
    model_read(CSR + 32'h8, e);
    exp_rd_q.push_back(e);
    @(posedge clk); #1;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = CSR + 32'h8; bus_be = 4'hF;
    resp_req = 1'b1; resp_data = d;
    @(negedge clk);
    check("pp_ack", 128'(bus_ack && resp_ack), 128'(1));
    m_fifo.push_back(d);
    @(posedge clk); #1;
    bus_req = 1'b0; resp_req = 1'b0;
    @(negedge clk);
    check("pp_resp_latency", 128'(bus_resp), 128'(1));
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    cmd_ack = 1'b1;
    @(posedge clk); #1;
    cmd_ack = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    check("cmd_req_drop", 128'(cmd_req), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_led",      128'(led), 128'(0));
    check("rst_cmd_req",  128'(cmd_req), 128'(0));
    check("rst_cmd_data", cmd_data, 128'(0));
    check("rst_bus_resp", 128'(bus_resp), 128'(0));
    check("rst_rdata",    128'(bus_rdata), 128'(0));
    check("rst_resp_ack", 128'(resp_ack), 128'(1));
    rd(CSR + 32'h4);

    // command staging and held launch
    for (int i = 0; i < CW; i++) wr(CSR + 32'h40 + 32'(4 * i), 32'(8'h11 * (i + 1)), 4'hF);
    wr(CSR, 32'h1, 4'hF);
    check("tp1_cmd_data", cmd_data, 128'h00000044_00000033_00000022_00000011);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tp1_req_held", 128'(cmd_req), 128'(1));
    end
    rd(CSR + 32'h4);
    handshake();

    // relaunch during busy: stall, then back-to-back request
    wr(CSR, 32'h1, 4'hF);
    wr(CSR + 32'h40, 32'h0000_00AA, 4'hF);
    @(posedge clk); #1;
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = CSR; bus_wdata = 32'h1; bus_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ack", 128'(bus_ack), 128'(0));
      @(posedge clk); #1;
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    check("b2b_ack", 128'(bus_ack), 128'(1));
    @(posedge clk); #1;
    bus_req = 1'b0; cmd_ack = 1'b0;
    exp_cmd_q.push_back(pack_stage());
    @(negedge clk);
    check("b2b_req", 128'(cmd_req), 128'(1));
    check("b2b_word0", 128'(cmd_data[31:0]), 128'(32'hAA));
    handshake();

    // FIFO fill, drain, underflow, W1C
    for (int i = 1; i <= 9; i++) push_resp(32'(i));
    rd(CSR + 32'h4);
    for (int i = 0; i < 9; i++) rd(CSR + 32'h8);
    rd(CSR + 32'h4);
    wr(CSR + 32'h4, 32'h2, 4'hF);
    rd(CSR + 32'h4);

    // concurrent push/pop with three entries, across pointer wrap
    for (int i = 0; i < 3; i++) push_resp(32'h100 + 32'(i));
    for (int i = 0; i < 10; i++) push_pop(32'h200 + 32'(i));
    rd(CSR + 32'h4);
    for (int i = 0; i < 3; i++) rd(CSR + 32'h8);

    // GPIO byte-enable and switch read, unmapped reads
    wr(32'h0, 32'h0000_FFFF, 4'b0001);
    check("led_be", 128'(led), 128'(16'h00FF));
    sw = 16'hA5A5;
    rd(32'h4);
    rd(32'h0);
    rd(32'h2000_0000);
    rd(CSR + 32'h00C);

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      int unsigned op, idx;
      logic [31:0] d, a;
      logic [3:0] be;
      op  = $urandom_range(0, 10);
      idx = $urandom_range(0, CW - 1);
      d   = $urandom;
      be  = 4'($urandom);
      case (op)
        0: wr(CSR + 32'h40 + 32'(4 * idx), d, be);
        1: rd(CSR + 32'h40 + 32'(4 * idx));
        2: begin
          wr(32'h0, d, be);
          check("led_o", 128'(led), 128'(m_led));
        end
        3: rd(32'h0);
        4: begin
          sw = 16'($urandom);
          rd(32'h4);
        end
        5, 6: push_resp(d);
        7: rd(CSR + 32'h8);
        8: if (be[3]) wr(CSR + 32'h4, d, be); else rd(CSR + 32'h4);
        9: begin
          a = be[0] ? (32'h2000_0000 | (d & 32'h0000_0FFC))
                    : (CSR + 32'h100 + (d & 32'h0000_0EFC));
          rd(a);
        end
        default: begin
          wr(CSR, 32'h1, 4'hF);
          repeat ($urandom_range(0, 4)) @(posedge clk);
          handshake();
        end
      endcase
    end

    // reset during an outstanding command with a read accepted in the same cycle
    wr(CSR + 32'h44, 32'h1234_5678, 4'hF);
    wr(32'h0, 32'h0000_BEEF, 4'hF);
    wr(CSR, 32'h1, 4'hF);
    push_resp(32'h55);
    push_resp(32'h66);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h4; bus_be = 4'hF;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus_req = 1'b0;
    @(negedge clk);
    check("mrst_cmd_req",  128'(cmd_req), 128'(0));
    check("mrst_cmd_data", cmd_data, 128'(0));
    check("mrst_bus_resp", 128'(bus_resp), 128'(0));
    check("mrst_led",      128'(led), 128'(0));
    check("mrst_resp_ack", 128'(resp_ack), 128'(1));
    rd(CSR + 32'h4);
    rd(CSR + 32'h44);
    rd(CSR + 32'h8);

    repeat (4) @(posedge clk);
    check("rd_queue_drained",  128'(exp_rd_q.size()), 128'(0));
    check("cmd_queue_drained", 128'(exp_cmd_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
